// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef logic port_id_t;

  localparam int DMEM_ARB_TIMEOUT_DEF = 64;

  // Response data replicated from this bit on write acks and aborts.
  localparam logic DMEM_ARB_ERR_DATA_BIT = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection; round-robin with last-grant pointer when DMEM_ARB_RR_EN
// is defined, otherwise fixed priority to port 0 with no pointer state.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     req0_i,
  input  logic     req1_i,
  input  logic     take_i,
  output port_id_t win_o
);

`ifdef DMEM_ARB_RR_EN
  port_id_t last_q, last_d;

  always_comb begin
    if (req0_i && req1_i) begin
      win_o = ~last_q;
    end else begin
      win_o = port_id_t'(req1_i && !req0_i);
    end
    last_d = last_q;
    if (take_i) begin
      last_d = win_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk_i, rst_i, take_i};
  assign win_o      = port_id_t'(req1_i && !req0_i);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (port 0) and loader/debug (port 1),
// one outstanding transaction with watchdog abort. DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DMEM_ARB_TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0,
  input  logic                i_req1,
  input  logic [ADDR_W-1:0]   i_addr0,
  input  logic [ADDR_W-1:0]   i_addr1,
  input  logic                i_wren0,
  input  logic                i_wren1,
  input  logic [DATA_W-1:0]   i_wdata0,
  input  logic [DATA_W-1:0]   i_wdata1,
  input  logic [DATA_W/8-1:0] i_strb0,
  input  logic [DATA_W/8-1:0] i_strb1,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_rvalid0,
  output logic                o_rvalid1,
  output logic                o_err0,
  output logic                o_err1,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_busy0,
  output logic                o_mem_req,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_strb,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  port_id_t            owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rv0_q, rv0_d, rv1_q, rv1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mreq_q, mreq_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                mwren_q, mwren_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;
  logic [STRB_W-1:0]   mstrb_q, mstrb_d;
  logic                take;
  logic                expired;
  port_id_t            win;

  rr_arb2 u_arb (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .req0_i (i_req0),
    .req1_i (i_req1),
    .take_i (take),
    .win_o  (win)
  );

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata_d  = rdata_q;
    mreq_d   = mreq_q;
    maddr_d  = maddr_q;
    mwren_d  = mwren_q;
    mwdata_d = mwdata_q;
    mstrb_d  = mstrb_q;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          take     = 1'b1;
          owner_d  = win;
          gnt0_d   = (win == 1'b0);
          gnt1_d   = (win == 1'b1);
          maddr_d  = win ? i_addr1  : i_addr0;
          mwren_d  = win ? i_wren1  : i_wren0;
          mwdata_d = win ? i_wdata1 : i_wdata0;
          mstrb_d  = win ? i_strb1  : i_strb0;
          mreq_d   = 1'b1;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Acceptance beats a watchdog expiry landing in the same cycle.
        if (i_mem_ready) begin
          mreq_d = 1'b0;
          if (mwren_q) begin
            rv0_d   = (owner_q == 1'b0);
            rv1_d   = (owner_q == 1'b1);
            rdata_d = {DATA_W{DMEM_ARB_ERR_DATA_BIT}};
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (expired) begin
          mreq_d  = 1'b0;
          rv0_d   = (owner_q == 1'b0);
          rv1_d   = (owner_q == 1'b1);
          err0_d  = (owner_q == 1'b0);
          err1_d  = (owner_q == 1'b1);
          rdata_d = {DATA_W{DMEM_ARB_ERR_DATA_BIT}};
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_rvalid) begin
          rv0_d   = (owner_q == 1'b0);
          rv1_d   = (owner_q == 1'b1);
          rdata_d = i_mem_rdata;
          state_d = IDLE;
        end else if (expired) begin
          rv0_d   = (owner_q == 1'b0);
          rv1_d   = (owner_q == 1'b1);
          err0_d  = (owner_q == 1'b0);
          err1_d  = (owner_q == 1'b1);
          rdata_d = {DATA_W{DMEM_ARB_ERR_DATA_BIT}};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata_q  <= '0;
      mreq_q   <= 1'b0;
      maddr_q  <= '0;
      mwren_q  <= 1'b0;
      mwdata_q <= '0;
      mstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata_q  <= rdata_d;
      mreq_q   <= mreq_d;
      maddr_q  <= maddr_d;
      mwren_q  <= mwren_d;
      mwdata_q <= mwdata_d;
      mstrb_q  <= mstrb_d;
    end
  end

  assign o_gnt0      = gnt0_q;
  assign o_gnt1      = gnt1_q;
  assign o_rvalid0   = rv0_q;
  assign o_rvalid1   = rv1_q;
  assign o_err0      = err0_q;
  assign o_err1      = err1_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mreq_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_wren  = mwren_q;
  assign o_mem_wdata = mwdata_q;
  assign o_mem_strb  = mstrb_q;
  // Stall holds through the response pulse so the LSU sees data before release.
  assign o_busy0     = i_req0 || ((state_q != IDLE) && (owner_q == 1'b0)) || rv0_q;

endmodule
